// File: rtl/gbuff_loader_pkg.sv
// ---------------------------------------------------------------------------
// gbuff_loader_pkg
//  Shared definitions for the global-buffer preload path: default word,
//  index and count widths, loader FSM state encoding, and a helper that
//  selects the first state entered after a descriptor is accepted.
//  No ports (package).
// ---------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package gbuff_loader_pkg;

   localparam int DEF_WORD_W = `WORD_SIZE;
   localparam int DEF_ADDR_W = `DATA_SIZE;
   localparam int DEF_CNT_W  = 8;
   localparam int DIM_W      = 4;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LOAD_A = 3'd1;
   localparam state_t ST_LOAD_B = 3'd2;
   // One cycle for the registered write of the final word to land in the
   // buffer before the TPU is started (also taken when no words are loaded).
   localparam state_t ST_FLUSH  = 3'd3;
   localparam state_t ST_START  = 3'd4;
   localparam state_t ST_RUN    = 3'd5;
   localparam state_t ST_FIN    = 3'd6;

   // First state after a descriptor handshake, skipping empty matrices.
   function automatic state_t first_load_state(input logic has_a, input logic has_b);
      if (has_a)
         return ST_LOAD_A;
      else if (has_b)
         return ST_LOAD_B;
      else
         return ST_FLUSH;
   endfunction

endpackage

// File: rtl/gbuff_wr_port.sv
// ---------------------------------------------------------------------------
// gbuff_wr_port
//  Registered write stage for one global-buffer write port. A request in
//  cycle N produces wr_en/index/data_in in cycle N+1. The index is the
//  word counter zero-extended to the buffer index width.
//  Ports:
//   clk, rst      clock / asynchronous active-low reset
//   wr_req        write request (word accepted this cycle)
//   wr_idx        word counter value for this write
//   wr_data       word to write
//   wr_en         registered write enable to the buffer
//   index         registered buffer index
//   data_in       registered buffer write data
// ---------------------------------------------------------------------------
module gbuff_wr_port
   import gbuff_loader_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [CNT_W-1:0]  wr_idx,
   input  logic [WORD_W-1:0] wr_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] index,
   output logic [WORD_W-1:0] data_in
);

   logic              wr_en_reg;
   logic [ADDR_W-1:0] index_reg;
   logic [WORD_W-1:0] data_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en_reg <= 1'b0;
         index_reg <= '0;
         data_reg  <= '0;
      end else begin
         wr_en_reg <= wr_req;
         if (wr_req) begin
            index_reg <= ADDR_W'(wr_idx);
            data_reg  <= wr_data;
         end
      end
   end

   assign wr_en   = wr_en_reg;
   assign index   = index_reg;
   assign data_in = data_reg;

endmodule

// File: rtl/gbuff_loader.sv
// ---------------------------------------------------------------------------
// gbuff_loader
//  Host-side preload stage ahead of the TPU. Accepts a job descriptor,
//  streams A then B words from the host into GBUFF_A / GBUFF_B, pulses
//  tpu_start, waits for tpu_done and reports completion with done.
//  Ports:
//   clk, rst                  clock / asynchronous active-low reset
//   cfg_valid/cfg_ready       descriptor handshake
//   cfg_m/k/n                 matrix dimensions (forwarded to the TPU)
//   cfg_num_a/cfg_num_b       A / B word counts (0 allowed)
//   in_valid/in_ready/in_data host word stream
//   wr_en_a/index_a/data_in_a GBUFF_A write port
//   wr_en_b/index_b/data_in_b GBUFF_B write port
//   tpu_start                 one-cycle start pulse
//   tpu_m/k/n                 dimensions latched at descriptor accept
//   tpu_done                  TPU completion (only honoured in RUN)
//   busy                      job in progress
//   done                      one-cycle job-complete pulse
// ---------------------------------------------------------------------------
module gbuff_loader
   import gbuff_loader_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DIM_W-1:0]  cfg_m,
   input  logic [DIM_W-1:0]  cfg_k,
   input  logic [DIM_W-1:0]  cfg_n,
   input  logic [CNT_W-1:0]  cfg_num_a,
   input  logic [CNT_W-1:0]  cfg_num_b,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              wr_en_a,
   output logic [ADDR_W-1:0] index_a,
   output logic [WORD_W-1:0] data_in_a,
   output logic              wr_en_b,
   output logic [ADDR_W-1:0] index_b,
   output logic [WORD_W-1:0] data_in_b,
   output logic              tpu_start,
   output logic [DIM_W-1:0]  tpu_m,
   output logic [DIM_W-1:0]  tpu_k,
   output logic [DIM_W-1:0]  tpu_n,
   input  logic              tpu_done,
   output logic              busy,
   output logic              done
);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc, cur_num;
   logic [CNT_W-1:0]  num_a_reg, num_b_reg;
   logic [DIM_W-1:0]  m_reg, k_reg, n_reg;
   // Low for the first cycle after reset so every output reads 0 while in reset.
   logic              alive_reg;
   logic              cfg_fire, in_fire, last_word;

   assign cfg_fire  = cfg_valid & cfg_ready;
   assign in_fire   = in_valid & in_ready;
   assign cnt_inc   = cnt_reg + CNT_W'(1);
   assign cur_num   = (state_reg == ST_LOAD_A) ? num_a_reg : num_b_reg;
   assign last_word = in_fire && (cnt_inc == cur_num);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         alive_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         alive_reg <= 1'b1;
      end
   end

   // Descriptor registers, held until the next accepted descriptor
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         num_a_reg <= '0;
         num_b_reg <= '0;
         m_reg     <= '0;
         k_reg     <= '0;
         n_reg     <= '0;
      end else if (cfg_fire) begin
         num_a_reg <= cfg_num_a;
         num_b_reg <= cfg_num_b;
         m_reg     <= cfg_m;
         k_reg     <= cfg_k;
         n_reg     <= cfg_n;
      end
   end

   // Next-state and word counter
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (cfg_fire) begin
               state_next = first_load_state(cfg_num_a != '0, cfg_num_b != '0);
               cnt_next   = '0;
            end
         end
         ST_LOAD_A: begin
            if (in_fire)
               cnt_next = last_word ? '0 : cnt_inc;
            if (last_word)
               state_next = (num_b_reg != '0) ? ST_LOAD_B : ST_FLUSH;
         end
         ST_LOAD_B: begin
            if (in_fire)
               cnt_next = last_word ? '0 : cnt_inc;
            if (last_word)
               state_next = ST_FLUSH;
         end
         ST_FLUSH: state_next = ST_START;
         ST_START: state_next = ST_RUN;
         ST_RUN:   if (tpu_done) state_next = ST_FIN;
         ST_FIN:   state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      tpu_start = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_reg)
         ST_IDLE:   cfg_ready = alive_reg;
         ST_LOAD_A,
         ST_LOAD_B: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         ST_FLUSH,
         ST_RUN:    busy = 1'b1;
         ST_START: begin
            tpu_start = 1'b1;
            busy      = 1'b1;
         end
         ST_FIN:    done = 1'b1;
         default: ;
      endcase
   end

   assign tpu_m = m_reg;
   assign tpu_k = k_reg;
   assign tpu_n = n_reg;

   // Buffer write ports: index 0 drives GBUFF_A, index 1 drives GBUFF_B
   logic [1:0]             wr_req, port_en;
   logic [1:0][ADDR_W-1:0] port_idx;
   logic [1:0][WORD_W-1:0] port_data;

   assign wr_req = {in_fire && (state_reg == ST_LOAD_B),
                    in_fire && (state_reg == ST_LOAD_A)};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_wr_port
         gbuff_wr_port #(
            .WORD_W (WORD_W),
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
         ) u_wr_port (
            .clk     (clk),
            .rst     (rst),
            .wr_req  (wr_req[gi]),
            .wr_idx  (cnt_reg),
            .wr_data (in_data),
            .wr_en   (port_en[gi]),
            .index   (port_idx[gi]),
            .data_in (port_data[gi])
         );
      end
   endgenerate

   assign wr_en_a   = port_en[0];
   assign index_a   = port_idx[0];
   assign data_in_a = port_data[0];
   assign wr_en_b   = port_en[1];
   assign index_b   = port_idx[1];
   assign data_in_b = port_data[1];

endmodule
